// File: rtl/cache_writeback_buffer.sv
// Write-back buffer for dirty lines evicted from the cache: an in-order FIFO toward the next
// memory level, with an associative lookup port so a refill can be served from a pending line.
module cache_writeback_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_BITS  = 2,
    parameter int ADDRESS_BITS = 32,
    parameter int INDEX_BITS   = 8,
    parameter int DEPTH        = 4,
    parameter int BLOCK_WIDTH  = DATA_WIDTH << OFFSET_BITS,
    parameter int TAG_BITS     = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS,
    parameter int CBITS        = $clog2(DEPTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    evict_valid,
    output logic                    evict_ready,
    input  logic [TAG_BITS-1:0]     evict_tag,
    input  logic [INDEX_BITS-1:0]   evict_index,
    input  logic [BLOCK_WIDTH-1:0]  evict_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [BLOCK_WIDTH-1:0]  mem_data,
    input  logic                    lookup_valid,
    input  logic [TAG_BITS-1:0]     lookup_tag,
    input  logic [INDEX_BITS-1:0]   lookup_index,
    output logic                    lookup_hit,
    output logic [BLOCK_WIDTH-1:0]  lookup_data,
    output logic                    full,
    output logic                    empty,
    output logic [CBITS-1:0]        count
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [TAG_BITS-1:0]    tag_mem   [DEPTH];
    logic [INDEX_BITS-1:0]  index_mem [DEPTH];
    logic [BLOCK_WIDTH-1:0] data_mem  [DEPTH];
    logic [DEPTH-1:0]       entry_valid;
    logic [PTR_BITS-1:0]    head;
    logic [PTR_BITS-1:0]    tail;
    logic                   push;
    logic                   pop;
    logic                   match_hit;
    logic [BLOCK_WIDTH-1:0] match_data;
    logic [PTR_BITS-1:0]    slot;

    assign full        = (count == CBITS'(DEPTH));
    assign empty       = (count == '0);
    assign evict_ready = !full;
    assign mem_valid   = !empty;
    assign push        = evict_valid && evict_ready;
    assign pop         = mem_valid && mem_ready;
    assign mem_address = {tag_mem[head], index_mem[head], {OFFSET_BITS{1'b0}}};
    assign mem_data    = data_mem[head];

    // Line storage carries no reset; entry_valid and count decide what is meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[tail]   <= evict_tag;
            index_mem[tail] <= evict_index;
            data_mem[tail]  <= evict_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + PTR_BITS'(1);
            end
            if (push) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + PTR_BITS'(1);
            end
            if (push && !pop) begin
                count <= count + CBITS'(1);
            end else if (pop && !push) begin
                count <= count - CBITS'(1);
            end
        end
    end

    // Scan oldest to youngest so the last match, the youngest duplicate, is the one kept.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        slot       = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_BITS'(k);
            if (entry_valid[slot] && tag_mem[slot] == lookup_tag &&
                index_mem[slot] == lookup_index) begin
                match_hit  = 1'b1;
                match_data = data_mem[slot];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lookup_hit  <= 1'b0;
            lookup_data <= '0;
        end else if (lookup_valid) begin
            lookup_hit  <= match_hit;
            lookup_data <= match_data;
        end else begin
            lookup_hit  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer: reset, push/pop, backpressure, lookup races and
// pointer wrap, each against hand-computed expectations.
module tb_cache_writeback_buffer;

    logic         clock;
    logic         reset;
    logic         evict_valid;
    logic         evict_ready;
    logic [21:0]  evict_tag;
    logic [7:0]   evict_index;
    logic [127:0] evict_data;
    logic         mem_valid;
    logic         mem_ready;
    logic [31:0]  mem_address;
    logic [127:0] mem_data;
    logic         lookup_valid;
    logic [21:0]  lookup_tag;
    logic [7:0]   lookup_index;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic         full;
    logic         empty;
    logic [2:0]   count;

    int assertions_evaluated = 0;
    int failures = 0;

    localparam logic [127:0] DATA_T2 = 128'h11555555_99999999_33777777_00001000;
    localparam logic [127:0] DATA_A  = 128'hAAAAAAAA_00000001_AAAAAAAA_00000001;
    localparam logic [127:0] DATA_B  = 128'hBBBBBBBB_00000002_BBBBBBBB_00000002;
    localparam logic [127:0] DATA_C  = 128'hCCCCCCCC_00000003_CCCCCCCC_00000003;
    localparam logic [127:0] DATA_E  = 128'hEEEEEEEE_00000004_EEEEEEEE_00000004;

    cache_writeback_buffer dut (
        .clock        (clock),
        .reset        (reset),
        .evict_valid  (evict_valid),
        .evict_ready  (evict_ready),
        .evict_tag    (evict_tag),
        .evict_index  (evict_index),
        .evict_data   (evict_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .lookup_valid (lookup_valid),
        .lookup_tag   (lookup_tag),
        .lookup_index (lookup_index),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [21:0] line_tag(input int i);
        return 22'h100000 + 22'(i);
    endfunction

    function automatic logic [7:0] line_index(input int i);
        return 8'h40 + 8'(i);
    endfunction

    function automatic logic [127:0] line_data(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    // Line i lands at {22'h100000+i, 8'h40+i, 2'b00} = 32'h40000100 + i*0x404.
    function automatic logic [31:0] line_address(input int i);
        return 32'h40000100 + 32'(i) * 32'h404;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertions_evaluated++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [21:0] tag,
                                 input logic [7:0] index, input logic [127:0] data);
        evict_valid = valid;
        evict_tag   = tag;
        evict_index = index;
        evict_data  = data;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        mem_ready    = 1'b0;
        lookup_valid = 1'b0;
        lookup_tag   = '0;
        lookup_index = '0;
        applyStimulus(1'b0, '0, '0, '0);

        $display("[TB] T1 asynchronous reset");
        tick();
        tick();
        #3 reset = 1'b0;
        #1;
        checkOutput("t1_empty", empty, 1'b1);
        checkOutput("t1_full", full, 1'b0);
        checkOutput("t1_count", count, 3'd0);
        checkOutput("t1_evict_ready", evict_ready, 1'b1);
        checkOutput("t1_mem_valid", mem_valid, 1'b0);
        checkOutput("t1_lookup_hit", lookup_hit, 1'b0);
        checkOutput("t1_lookup_data", lookup_data, '0);
        reset = 1'b1;
        tick();

        $display("[TB] T2 single push");
        applyStimulus(1'b1, 22'h1CCCCC, 8'd1, DATA_T2);
        #1;
        checkOutput("t2_no_bypass", mem_valid, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("t2_mem_valid", mem_valid, 1'b1);
        checkOutput("t2_mem_address", mem_address, 32'h73333004);
        checkOutput("t2_mem_data", mem_data, DATA_T2);
        checkOutput("t2_count", count, 3'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t2_hold_valid", mem_valid, 1'b1);
            checkOutput("t2_hold_address", mem_address, 32'h73333004);
            checkOutput("t2_hold_data", mem_data, DATA_T2);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("t2_empty", empty, 1'b1);
        checkOutput("t2_count_zero", count, 3'd0);

        $display("[TB] T3 full and backpressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, line_tag(i), line_index(i), line_data(i));
            tick();
        end
        checkOutput("t3_full", full, 1'b1);
        checkOutput("t3_evict_ready", evict_ready, 1'b0);
        checkOutput("t3_count_full", count, 3'd4);
        applyStimulus(1'b1, line_tag(4), line_index(4), line_data(4));
        tick();
        checkOutput("t3_fifth_pending", count, 3'd4);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("t3_pop_count", count, 3'd3);
        checkOutput("t3_ready_again", evict_ready, 1'b1);
        checkOutput("t3_head_after_pop", mem_address, line_address(1));
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("t3_fifth_accepted", count, 3'd4);
        mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput("t3_drain_address", mem_address, line_address(i));
            checkOutput("t3_drain_data", mem_data, line_data(i));
            tick();
            checkOutput("t3_drain_count", count, 3'(4 - i));
        end
        mem_ready = 1'b0;
        checkOutput("t3_drained_empty", empty, 1'b1);

        $display("[TB] T4 lookup with duplicates");
        applyStimulus(1'b1, 22'h2BBBBB, 8'd1, DATA_A);
        tick();
        applyStimulus(1'b1, 22'h2BBBBB, 8'd1, DATA_B);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        lookup_valid = 1'b1;
        lookup_tag   = 22'h2BBBBB;
        lookup_index = 8'd1;
        tick();
        lookup_valid = 1'b0;
        checkOutput("t4_hit", lookup_hit, 1'b1);
        checkOutput("t4_youngest_data", lookup_data, DATA_B);
        tick();
        checkOutput("t4_idle_hit", lookup_hit, 1'b0);
        checkOutput("t4_idle_data_held", lookup_data, DATA_B);
        lookup_valid = 1'b1;
        lookup_tag   = 22'h2BB123;
        tick();
        lookup_valid = 1'b0;
        checkOutput("t4_miss_hit", lookup_hit, 1'b0);
        checkOutput("t4_miss_data", lookup_data, '0);
        mem_ready = 1'b1;
        checkOutput("t4_drain_first", mem_data, DATA_A);
        tick();
        checkOutput("t4_drain_second", mem_data, DATA_B);
        tick();
        mem_ready = 1'b0;
        checkOutput("t4_empty", empty, 1'b1);

        $display("[TB] T5 lookup races");
        applyStimulus(1'b1, 22'h3AAAAA, 8'd1, DATA_C);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        mem_ready    = 1'b1;
        lookup_valid = 1'b1;
        lookup_tag   = 22'h3AAAAA;
        lookup_index = 8'd1;
        tick();
        mem_ready = 1'b0;
        checkOutput("t5_pop_race_hit", lookup_hit, 1'b1);
        checkOutput("t5_pop_race_data", lookup_data, DATA_C);
        checkOutput("t5_popped_empty", empty, 1'b1);
        tick();
        checkOutput("t5_after_pop_hit", lookup_hit, 1'b0);
        checkOutput("t5_after_pop_data", lookup_data, '0);
        applyStimulus(1'b1, 22'h3AAAAA, 8'd2, DATA_E);
        lookup_index = 8'd2;
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("t5_push_race_hit", lookup_hit, 1'b0);
        checkOutput("t5_push_count", count, 3'd1);
        tick();
        lookup_valid = 1'b0;
        checkOutput("t5_later_hit", lookup_hit, 1'b1);
        checkOutput("t5_later_data", lookup_data, DATA_E);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("t5_empty", empty, 1'b1);

        $display("[TB] T6 streaming across pointer wrap");
        mem_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, line_tag(i), line_index(i), line_data(i));
            tick();
            checkOutput("t6_count", count, 3'd1);
            checkOutput("t6_address", mem_address, line_address(i));
            checkOutput("t6_data", mem_data, line_data(i));
        end
        applyStimulus(1'b0, '0, '0, '0);
        tick();
        mem_ready = 1'b0;
        checkOutput("t6_empty", empty, 1'b1);

        $display("[TB] reset while occupied");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, line_tag(i), line_index(i), line_data(i));
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("rst_count_before", count, 3'd2);
        #3 reset = 1'b0;
        #1;
        checkOutput("rst_count", count, 3'd0);
        checkOutput("rst_mem_valid", mem_valid, 1'b0);
        checkOutput("rst_evict_ready", evict_ready, 1'b1);
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
